// File: rtl/lse_job_scheduler.sv
// lse_job_scheduler: round-robin job arbiter with solver launch, watchdog and response return; ports: req_* requests, sol_* solver handshake, rsp_* completion, sel_idx/busy status
module lse_job_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int RANK_MAX = 936,
  parameter int TIMEOUT = 1048575
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ*$clog2(RANK_MAX+1)-1:0]  req_rank,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic [$clog2(NUM_REQ)-1:0]             sel_idx,
  output logic [$clog2(RANK_MAX+1)-1:0]          sol_rank,
  output logic                                   sol_start,
  input  logic                                   sol_done,
  output logic                                   sol_abort,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]             rsp_id,
  output logic [1:0]                             rsp_status,
  output logic                                   busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int RW = $clog2(RANK_MAX+1);
  localparam int CW = $clog2(TIMEOUT+1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] rr_ptr, win;
  logic [RW-1:0] win_rank;
  logic [CW-1:0] wd;
  logic found, bad, done_ok, tmo;
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[IW'((int'(rr_ptr) + i) % NUM_REQ)]) begin
        found = 1'b1;
        win = IW'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end
  assign win_rank = req_rank[int'(win)*RW +: RW];
  assign bad = win_rank > RW'(RANK_MAX);
  assign done_ok = sol_done && wd != '0;
  assign tmo = wd == CW'(TIMEOUT-1);
  always_comb begin
    state_nx = state == IDLE   ? (found ? (bad ? RESP : LAUNCH) : IDLE) :
               state == LAUNCH ? WAIT :
               state == WAIT   ? ((done_ok || tmo) ? RESP : WAIT) :
                                 (rsp_ready ? IDLE : RESP);
    req_ready = (state == IDLE && found) ? NUM_REQ'(1) << win : '0;
    sol_start = state == LAUNCH;
    sol_abort = state == WAIT && tmo && !done_ok;
    rsp_valid = state == RESP;
    busy = state != IDLE;
  end
  assign rsp_id = sel_idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      sel_idx <= '0;
      sol_rank <= '0;
      rsp_status <= 2'b00;
      wd <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        sel_idx <= win;
        sol_rank <= win_rank;
        rr_ptr <= (win == IW'(NUM_REQ-1)) ? '0 : win + 1'b1;
        rsp_status <= bad ? 2'b10 : 2'b00;
      end
      if (state == LAUNCH) wd <= '0;
      else if (state == WAIT && wd != '1) wd <= wd + 1'b1;
      if (state == WAIT) rsp_status <= done_ok ? 2'b00 : 2'b01;
    end
  end
endmodule

// File: tb/tb_lse_job_scheduler.sv
// tb_lse_job_scheduler: randomized and directed checks of lse_job_scheduler against a job-level reference model
module tb_lse_job_scheduler;
  logic clk, rst;
  logic [3:0] req_valid, req_ready;
  logic [39:0] req_rank;
  logic [1:0] sel_idx, rsp_id, rsp_status;
  logic [9:0] sol_rank;
  logic sol_start, sol_done, sol_abort, rsp_valid, rsp_ready, busy;
  logic [3:0] req_valid_b, req_ready_b;
  logic [39:0] req_rank_b;
  logic [1:0] sel_idx_b, rsp_id_b, rsp_status_b;
  logic [9:0] sol_rank_b;
  logic sol_start_b, sol_done_b, sol_abort_b, rsp_valid_b, rsp_ready_b, busy_b;
  int pass_n, tot_n, mrr, cyc, st, lat_a;
  bit started, keep_done;
  lse_job_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rank(req_rank), .req_ready(req_ready),
    .sel_idx(sel_idx), .sol_rank(sol_rank), .sol_start(sol_start), .sol_done(sol_done),
    .sol_abort(sol_abort), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_status(rsp_status), .busy(busy)
  );
  lse_job_scheduler #(.TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_rank(req_rank_b), .req_ready(req_ready_b),
    .sel_idx(sel_idx_b), .sol_rank(sol_rank_b), .sol_start(sol_start_b), .sol_done(sol_done_b),
    .sol_abort(sol_abort_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_id(rsp_id_b),
    .rsp_status(rsp_status_b), .busy(busy_b)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) started <= 1'b0;
    else if (sol_start) begin
      started <= 1'b1;
      st <= cyc;
    end
  end
  assign sol_done = keep_done || (started && (cyc - st >= lat_a));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot_n++;
    assert (got === exp) pass_n++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask
  function automatic int pick(input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++) if (v[(p + i) % 4]) return (p + i) % 4;
    return 0;
  endfunction
  task automatic job(input logic [3:0] v, input logic [39:0] rk, input int lat, input bit keep, input int bp);
    int w, n, exp_n;
    logic [9:0] r;
    bit ab, stable;
    req_valid = v;
    req_rank = rk;
    keep_done = keep;
    lat_a = lat;
    rsp_ready = bp == 0;
    #1;
    w = pick(v, mrr);
    r = rk[w*10 +: 10];
    mrr = (w + 1) % 4;
    chk("req_ready", req_ready, 32'(4'b1 << w));
    chk("idle_busy", busy, 0);
    @(negedge clk);
    chk("launch_start", sol_start, r <= 936);
    chk("launch_ready", req_ready, 0);
    chk("sel_idx", sel_idx, w);
    chk("sol_rank", sol_rank, r);
    n = 0;
    ab = 1'b0;
    while (!rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
      ab |= sol_abort;
    end
    exp_n = r > 936 ? 0 : ((lat < 2) ? 2 : lat) + 1;
    chk("rsp_latency", n, exp_n);
    chk("no_abort", ab, 0);
    chk("rsp_id", rsp_id, w);
    chk("rsp_status", rsp_status, r > 936 ? 2 : 0);
    if (bp > 0) begin
      stable = 1'b1;
      repeat (bp) begin
        @(negedge clk);
        stable &= rsp_valid && rsp_id == 2'(w) && req_ready == 0 && !sol_start;
      end
      chk("bp_hold", stable, 1);
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("idle_after", {busy, rsp_valid}, 0);
  endtask
  initial begin
    int n;
    rst = 1'b1;
    req_valid = '0;
    req_rank = '0;
    rsp_ready = 1'b1;
    keep_done = 1'b0;
    lat_a = 0;
    req_valid_b = '0;
    req_rank_b = '0;
    rsp_ready_b = 1'b1;
    sol_done_b = 1'b0;
    mrr = 0;
    repeat (2) @(negedge clk);
    chk("reset_state", {req_ready, sol_start, sol_abort, rsp_valid, rsp_status, rsp_id, sel_idx, sol_rank, busy}, 0);
    rst = 1'b0;
    job(4'b0100, {10'd0, 10'd8, 10'd0, 10'd0}, 100, 0, 0);
    job(4'b0010, {10'd0, 10'd0, 10'd937, 10'd0}, 0, 0, 0);
    job(4'b1000, {10'd100, 10'd0, 10'd0, 10'd0}, 5, 0, 20);
    job(4'b0001, 40'd0, 0, 1, 0);
    for (int i = 0; i < 12; i++)
      job(4'($urandom_range(1, 15)),
          {10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
           10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))},
          $urandom_range(0, 30), 0, $urandom_range(0, 3));
    req_valid = 4'b0100;
    req_rank = {10'd0, 10'd8, 10'd0, 10'd0};
    lat_a = 50;
    @(negedge clk);
    repeat (2) @(negedge clk);
    chk("wait_busy", busy, 1);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_reset", {req_ready, sol_start, sol_abort, rsp_valid, rsp_status, rsp_id, sel_idx, sol_rank, busy}, 0);
    mrr = 0;
    for (int i = 0; i < 8; i++) job(4'hF, {4{10'(8 + i)}}, 3, 0, 0);
    req_valid = '0;
    req_valid_b = 4'b0001;
    req_rank_b = 40'd5;
    #1;
    chk("b_ready", req_ready_b, 1);
    @(negedge clk);
    req_valid_b = '0;
    chk("b_start", sol_start_b, 1);
    n = 0;
    while (!sol_abort_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b_abort_at", n, 16);
    chk("b_abort_rsp", rsp_valid_b, 0);
    @(negedge clk);
    chk("b_abort_pulse", sol_abort_b, 0);
    chk("b_tmo_valid", rsp_valid_b, 1);
    chk("b_tmo_status", rsp_status_b, 1);
    @(negedge clk);
    chk("b_idle", busy_b, 0);
    sol_done_b = 1'b1;
    req_valid_b = 4'b0001;
    @(negedge clk);
    req_valid_b = '0;
    n = 0;
    while (!rsp_valid_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b_ok_latency", n, 3);
    chk("b_ok_status", rsp_status_b, 0);
    @(negedge clk);
    sol_done_b = 1'b0;
    req_valid_b = 4'b0001;
    @(negedge clk);
    req_valid_b = '0;
    repeat (16) @(negedge clk);
    sol_done_b = 1'b1;
    #1;
    chk("b_coincide_abort", sol_abort_b, 0);
    @(negedge clk);
    chk("b_coincide_valid", rsp_valid_b, 1);
    chk("b_coincide_status", rsp_status_b, 0);
    sol_done_b = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
